sreg_file_mp: RTL



---
 rtl/vp_sreg_pkg.sv | 19 +
 rtl/sreg_lane_merge.sv | 25 ++
 rtl/sreg_file_mp.sv | 99 +++++++++
 3 files changed

// File: rtl/vp_sreg_pkg.sv
// Shared definitions for the vertex-processor register files: default geometry,
// sweeper state encoding and lane-count derivation.
package vp_sreg_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_LANE_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sreg_state_t;

    function automatic int unsigned lanes_of(input int unsigned data_w,
                                             input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/sreg_lane_merge.sv
// Per-lane merge of new data into an existing entry; shared by the array write
// path and the read bypass so both always agree.
module sreg_lane_merge
    import vp_sreg_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned LANE_W = DEF_LANE_W,
    localparam int unsigned LANES  = lanes_of(DATA_W, LANE_W)
) (
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [LANES-1:0]  mask,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/sreg_file_mp.sv
// Special register file: N registered read ports, lane-masked writes with
// write-first bypass, and a clear sweeper that zeroes every entry after reset/on request.
module sreg_file_mp
    import vp_sreg_pkg::*;
#(
    parameter  int unsigned ADDR_W = DEF_ADDR_W,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned LANE_W = DEF_LANE_W,
    parameter  int unsigned N_RD   = 2,
    localparam int unsigned LANES  = lanes_of(DATA_W, LANE_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [LANES-1:0]         w_mask,
    input  logic [N_RD*ADDR_W-1:0]   r_addr,
    output logic [N_RD*DATA_W-1:0]   r_data,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    sreg_state_t       state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    // A clear request in the same cycle as a write takes priority and drops it.
    assign wr_ok  = (state == ST_IDLE) && we && !clr_req;
    assign wr_old = mem[w_addr];

    sreg_lane_merge #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_merge (
        .old_data (wr_old),
        .new_data (w_data),
        .mask     (w_mask),
        .merged   (wr_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        cnt   <= '0;
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[w_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            for (int unsigned p = 0; p < N_RD; p++) begin
                if (state == ST_CLEAR) begin
                    r_data[p*DATA_W +: DATA_W] <= '0;
                end else if (wr_ok && (r_addr[p*ADDR_W +: ADDR_W] == w_addr)) begin
                    r_data[p*DATA_W +: DATA_W] <= wr_merged;
                end else begin
                    r_data[p*DATA_W +: DATA_W] <= mem[r_addr[p*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

endmodule
